// File: rtl/sd_req_arbiter.sv
// sd_req_arbiter
// Shares the single SD block-request port of the I/O block between up to
// four virtual-drive requesters. It does round-robin arbitration in IDLE,
// latches the winner's LBA and direction, then walks one sector transaction
// through the firmware ack handshake.
//
// Ports
//   clk_sys, reset        system clock, synchronous active-high reset
//   req_rd/req_wr/req_lba per-requester level requests and LBA slices
//   done/err              one-cycle completion / timeout pulses to the owner
//   busy, sel             FSM not idle; current or last granted index
//   buff_wr               sd_buff_wr_in steered to requester sel (combinational)
//   sd_lba/sd_rd/sd_wr    command to the I/O block
//   sd_ack, sd_buff_wr_in handshake and buffer strobe from the I/O block
`timescale 1ns/1ps

module sd_req_arbiter #(
    parameter int          NREQ    = 2,
    parameter logic [23:0] TIMEOUT = 24'd10000000
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_rd,
    input  logic [NREQ-1:0]      req_wr,
    input  logic [32*NREQ-1:0]   req_lba,
    output logic [NREQ-1:0]      done,
    output logic [NREQ-1:0]      err,
    output logic                 busy,
    output logic [1:0]           sel,
    output logic [NREQ-1:0]      buff_wr,
    output logic [31:0]          sd_lba,
    output logic                 sd_rd,
    output logic                 sd_wr,
    input  logic                 sd_ack,
    input  logic                 sd_buff_wr_in
);

    typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

    state_t           state;
    logic [1:0]       ptr;
    logic [23:0]      tmo;
    logic             ack_meta, ack_s, ack_d;
    logic             ack_rise, ack_fall;

    // Requests padded to four slots so a 2-bit index is always in range.
    logic [3:0]       pend4, rd4;
    logic [3:0][31:0] lba4;
    logic [NREQ-1:0]  sel_oh;
    logic             gnt_found;
    logic [1:0]       gnt_idx, cand;

    assign ack_rise = ack_s & ~ack_d;
    assign ack_fall = ~ack_s & ack_d;

    always_comb begin
        pend4 = '0;
        rd4   = '0;
        lba4  = '0;
        for (int i = 0; i < NREQ; i++) begin
            pend4[i] = req_rd[i] | req_wr[i];
            rd4[i]   = req_rd[i];
            lba4[i]  = req_lba[32*i +: 32];
        end
    end

    // Scan upward from ptr+1 so the last winner has lowest priority.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = 2'((int'(ptr) + k) % NREQ);
            if (!gnt_found && pend4[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Owner decode; buffer strobes follow sel in every state so a late
    // strobe after ack falls still lands on the owner.
    for (genvar i = 0; i < NREQ; i++) begin : g_req
        assign sel_oh[i]  = (sel == 2'(i));
        assign buff_wr[i] = sd_buff_wr_in & sel_oh[i];
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= 2'(NREQ - 1);
            tmo      <= '0;
            sel      <= '0;
            sd_lba   <= '0;
            sd_rd    <= 1'b0;
            sd_wr    <= 1'b0;
            busy     <= 1'b0;
            done     <= '0;
            err      <= '0;
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
            ack_d    <= 1'b0;
        end else begin
            ack_meta <= sd_ack;
            ack_s    <= ack_meta;
            ack_d    <= ack_s;
            done     <= '0;
            err      <= '0;
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        sel    <= gnt_idx;
                        ptr    <= gnt_idx;
                        sd_lba <= lba4[gnt_idx];
                        tmo    <= '0;
                        // Read wins when both are held; the write is
                        // picked up on a later grant.
                        sd_rd  <= rd4[gnt_idx];
                        sd_wr  <= ~rd4[gnt_idx];
                        busy   <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    tmo <= tmo + 24'd1;
                    if (ack_rise) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        state <= XFER;
                    end else if (tmo == TIMEOUT - 24'd1) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        done  <= sel_oh;
                        err   <= sel_oh;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                XFER: begin
                    if (ack_fall) begin
                        done  <= sel_oh;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
